// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : riscv_fetch_pkg
// Brief    : Shared state encoding and default sizing for the fetch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_fetch_pkg;

    localparam int unsigned PC_W_DEF     = 8;
    localparam int unsigned INSTR_W_DEF  = 32;
    localparam int unsigned PC_STEP_DEF  = 4;
    localparam logic [7:0]  TRAP_VEC_DEF = 8'hF0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        HOLD   = 3'd3,
        DRAIN  = 3'd4,
        HALTED = 3'd5
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_out_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_out_buf
// Brief    : One-entry valid/ready instruction buffer toward decode, with flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_out_buf #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               flush_i,
    input  logic               ready_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o
);

    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    pc_q;

    // Flush wins over both load and consume so a redirected entry never leaks out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            if (flush_i) begin
                valid_q <= 1'b0;
            end else if (load_i) begin
                valid_q <= 1'b1;
            end else if (ready_i) begin
                valid_q <= 1'b0;
            end
            if (load_i) begin
                instr_q <= instr_i;
                pc_q    <= pc_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : PC next-value control, imem req/rvalid sequencing and decode buffer.
// Config   : define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned     PC_W     = PC_W_DEF,
    parameter int unsigned     INSTR_W  = INSTR_W_DEF,
    parameter int unsigned     PC_STEP  = PC_STEP_DEF,
    parameter logic [PC_W-1:0] TRAP_VEC = PC_W'(TRAP_VEC_DEF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PC_W-1:0]    pc_cur,
    output logic [PC_W-1:0]    pc_next,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_target,
    input  logic               halt,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    input  logic               if_ready,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic               misalign_trap,
`endif
    output logic               halted
);

    fetch_state_e    state_q, state_d;
    logic            halt_pend_q;
    logic            w_redir_act;
    logic            w_load;
    logic [PC_W-1:0] w_redir_pc;

    // Redirects only matter while a fetch stream is live.
    assign w_redir_act = redirect_valid &&
                         ((state_q == FETCH) || (state_q == WAIT) ||
                          (state_q == HOLD)  || (state_q == DRAIN));

`ifdef FETCH_MISALIGN_TRAP_EN
    logic w_misaligned;
    assign w_misaligned  = |redirect_target[1:0];
    assign w_redir_pc    = w_misaligned ? TRAP_VEC : redirect_target;
    assign misalign_trap = w_redir_act && w_misaligned;
`else
    assign w_redir_pc    = redirect_target & ~PC_W'(3);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            halt_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (halt) begin
                halt_pend_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_next  = pc_cur;
        imem_req = 1'b0;
        w_load   = 1'b0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (redirect_valid) begin
                    // Request still goes out; its response is discarded in DRAIN.
                    imem_req = 1'b1;
                    pc_next  = w_redir_pc;
                    state_d  = DRAIN;
                end else if (halt_pend_q) begin
                    state_d = HALTED;
                end else begin
                    imem_req = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_next = w_redir_pc;
                    state_d = imem_rvalid ? FETCH : DRAIN;
                end else if (imem_rvalid) begin
                    w_load  = 1'b1;
                    pc_next = pc_cur + PC_W'(PC_STEP);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_next = w_redir_pc;
                    state_d = FETCH;
                end else if (if_ready) begin
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                // A response arriving alongside a new redirect still retires the killed request.
                if (redirect_valid) begin
                    pc_next = w_redir_pc;
                end
                if (imem_rvalid) begin
                    state_d = FETCH;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    assign imem_addr = pc_cur;
    assign halted    = (state_q == HALTED);

    fetch_out_buf #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_out_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (w_load),
        .flush_i (w_redir_act),
        .ready_i (if_ready),
        .instr_i (imem_rdata),
        .pc_i    (pc_cur),
        .valid_o (if_valid),
        .instr_o (if_instr),
        .pc_o    (if_pc)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Self-checking bench with external PC register and imem responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pc_cur;
    logic [7:0]  pc_next;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_target = 8'h00;
    logic        halt = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [7:0]  if_pc;
    logic        if_ready = 1'b1;
    logic        halted;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    int          checks = 0;
    int          errors = 0;
    int          lat = 1;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_addr = 8'h00;

    logic        o_req, o_valid, o_dv, o_halted, o_trap;
    logic [7:0]  o_addr, o_pc, o_pcn, o_pcc;
    logic [31:0] o_instr;

    fetch_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_cur          (pc_cur),
        .pc_next         (pc_next),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt            (halt),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_ready        (if_ready),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misalign_trap   (misalign_trap),
`endif
        .halted          (halted)
    );

    always #5 clk = ~clk;

    // External PC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_cur <= 8'h00;
        else        pc_cur <= pc_next;
    end

    function automatic logic [31:0] instr_of(input logic [7:0] a);
        return {16'hC0DE, ~a, a};
    endfunction

    function automatic logic [7:0] pop_exp();
        if (exp_q.size() == 0) return 8'hxx;
        return exp_q.pop_front();
    endfunction

    // Instruction memory: responds 'lat' cycles after each request.
    initial begin
        logic       req_now;
        logic       pend;
        logic [7:0] a;
        logic [7:0] paddr;
        int         cnt;
        pend = 1'b0; cnt = 0; paddr = 8'h00;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            req_now = imem_req;
            a       = imem_addr;
            @(posedge clk); #1;
            imem_rvalid = 1'b0;
            if (!rst_n) begin pend = 1'b0; req_now = 1'b0; end
            if (pend) begin
                if (cnt == 0) begin imem_rvalid = 1'b1; imem_rdata = instr_of(paddr); pend = 1'b0; end
                else cnt--;
            end
            if (req_now) begin
                if (lat <= 1) begin imem_rvalid = 1'b1; imem_rdata = instr_of(a); end
                else begin pend = 1'b1; cnt = lat - 2; paddr = a; end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        o_req = imem_req;  o_addr = imem_addr; o_valid = if_valid;
        o_dv  = if_valid && if_ready; o_pc = if_pc; o_instr = if_instr;
        o_halted = halted; o_pcn = pc_next; o_pcc = pc_cur; o_trap = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        o_trap = misalign_trap;
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_ready = 1'b1; lat = 1;
        tick();
        checks++; if (o_valid !== 1'b0)     begin errors++; $display("FAIL reset_if_valid got %b want 0", o_valid); end
        checks++; if (o_instr !== 32'h0)    begin errors++; $display("FAIL reset_if_instr got %h want 0", o_instr); end
        checks++; if (o_pc !== 8'h00)       begin errors++; $display("FAIL reset_if_pc got %h want 00", o_pc); end
        checks++; if (o_req !== 1'b0)       begin errors++; $display("FAIL reset_imem_req got %b want 0", o_req); end
        checks++; if (o_halted !== 1'b0)    begin errors++; $display("FAIL reset_halted got %b want 0", o_halted); end
        checks++; if (o_pcn !== 8'h00)      begin errors++; $display("FAIL reset_pc_next got %h want 00", o_pcn); end
        rst_n = 1'b1; exp_q.delete(); exp_addr = 8'h00;
    endtask

    task automatic test_sequential();
        int n = 0;
        logic [7:0] e;
        for (int i = 0; i < 40 && n < 3; i++) begin
            tick();
            if (o_req) begin
                checks++; if (o_addr !== exp_addr) begin errors++; $display("FAIL seq_addr got %h want %h", o_addr, exp_addr); end
                exp_q.push_back(exp_addr); exp_addr += 8'd4;
            end
            if (o_dv) begin
                e = pop_exp(); n++;
                checks++; if (o_pc !== e || o_instr !== instr_of(e)) begin errors++; $display("FAIL seq_deliver got %h/%h want %h/%h", o_pc, o_instr, e, instr_of(e)); end
            end
        end
        checks++; if (n < 3) begin errors++; $display("FAIL seq_timeout got %0d want 3 deliveries", n); end
    endtask

    task automatic test_backpressure();
        logic found = 1'b0;
        logic [7:0] f;
        int nreq = 0;
        if_ready = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (o_req) begin
                checks++; if (o_addr !== exp_addr) begin errors++; $display("FAIL bp_addr got %h want %h", o_addr, exp_addr); end
                exp_q.push_back(exp_addr); exp_addr += 8'd4;
            end
            if (o_valid) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL bp_timeout got no if_valid want if_valid"); end
        f = (exp_q.size() > 0) ? exp_q[0] : 8'hxx;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (o_valid !== 1'b1 || o_pc !== f || o_instr !== instr_of(f)) begin errors++; $display("FAIL bp_stable got %b %h/%h want 1 %h/%h", o_valid, o_pc, o_instr, f, instr_of(f)); end
            checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL bp_req got %b want 0", o_req); end
            checks++; if (o_pcc !== f + 8'd4) begin errors++; $display("FAIL bp_pc_cur got %h want %h", o_pcc, f + 8'd4); end
        end
        if_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (o_dv) begin
                f = pop_exp();
                checks++; if (o_pc !== f) begin errors++; $display("FAIL bp_deliver got %h want %h", o_pc, f); end
            end
            if (o_req) begin
                nreq++;
                checks++; if (o_addr !== exp_addr) begin errors++; $display("FAIL bp_addr2 got %h want %h", o_addr, exp_addr); end
                exp_q.push_back(exp_addr); exp_addr += 8'd4;
            end
        end
        checks++; if (nreq != 1) begin errors++; $display("FAIL bp_req_count got %0d want 1", nreq); end
    endtask

    // Advance until a request is seen, handling deliveries on the way.
    task automatic find_req(input string tag);
        logic found = 1'b0;
        logic [7:0] e;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (o_dv) begin
                e = pop_exp();
                checks++; if (o_pc !== e || o_instr !== instr_of(e)) begin errors++; $display("FAIL %s_pre_deliver got %h want %h", tag, o_pc, e); end
            end
            if (o_req) begin
                checks++; if (o_addr !== exp_addr) begin errors++; $display("FAIL %s_pre_addr got %h want %h", tag, o_addr, exp_addr); end
                exp_q.push_back(exp_addr); exp_addr += 8'd4; found = 1'b1;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL %s_req_timeout got no req want req", tag); end
    endtask

    // Run until 'want' deliveries, checking addresses and data against the scoreboard.
    task automatic run_deliver(input string tag, input int want);
        int n = 0;
        logic [7:0] e;
        for (int i = 0; i < 30 && n < want; i++) begin
            tick();
            checks++; if (o_trap !== 1'b0) begin errors++; $display("FAIL %s_trap_len got %b want 0", tag, o_trap); end
            if (o_req) begin
                checks++; if (o_addr !== exp_addr) begin errors++; $display("FAIL %s_addr got %h want %h", tag, o_addr, exp_addr); end
                exp_q.push_back(exp_addr); exp_addr += 8'd4;
            end
            if (o_dv) begin
                e = pop_exp(); n++;
                checks++; if (o_pc !== e || o_instr !== instr_of(e)) begin errors++; $display("FAIL %s_deliver got %h/%h want %h/%h", tag, o_pc, o_instr, e, instr_of(e)); end
            end
        end
        checks++; if (n < want) begin errors++; $display("FAIL %s_timeout got %0d want %0d", tag, n, want); end
    endtask

    task automatic test_redirect_wait();
        lat = 2;
        find_req("rw");
        redirect_valid = 1'b1; redirect_target = 8'h40;
        tick();
        checks++; if (o_pcn !== 8'h40) begin errors++; $display("FAIL rw_pc_next got %h want 40", o_pcn); end
        redirect_valid = 1'b0; exp_q.delete(); exp_addr = 8'h40; lat = 1;
        run_deliver("rw", 1);
    endtask

    task automatic test_redirect_hold();
        lat = 1; if_ready = 1'b1;
        find_req("rh");
        tick();
        redirect_valid = 1'b1; redirect_target = 8'h20;
        tick();
        checks++; if (o_pcn !== 8'h20) begin errors++; $display("FAIL rh_pc_next got %h want 20", o_pcn); end
        redirect_valid = 1'b0; exp_q.delete(); exp_addr = 8'h20;
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rh_dropped got %b want 0", o_valid); end
        checks++; if (o_req !== 1'b1 || o_addr !== 8'h20) begin errors++; $display("FAIL rh_next_fetch got %b@%h want 1@20", o_req, o_addr); end
        if (o_req) begin exp_q.push_back(exp_addr); exp_addr += 8'd4; end
        run_deliver("rh", 1);
    endtask

    task automatic test_wrap();
        find_req("wr");
        redirect_valid = 1'b1; redirect_target = 8'hFC;
        tick();
        checks++; if (o_pcn !== 8'hFC) begin errors++; $display("FAIL wr_pc_next got %h want fc", o_pcn); end
        redirect_valid = 1'b0; exp_q.delete(); exp_addr = 8'hFC;
        run_deliver("wr", 2);
    endtask

    task automatic test_misalign();
        find_req("ma");
        redirect_valid = 1'b1; redirect_target = 8'h42;
        tick();
`ifdef FETCH_MISALIGN_TRAP_EN
        checks++; if (o_pcn !== 8'hF0) begin errors++; $display("FAIL ma_pc_next got %h want f0", o_pcn); end
        checks++; if (o_trap !== 1'b1) begin errors++; $display("FAIL ma_trap got %b want 1", o_trap); end
        exp_addr = 8'hF0;
`else
        checks++; if (o_pcn !== 8'h40) begin errors++; $display("FAIL ma_pc_next got %h want 40", o_pcn); end
        exp_addr = 8'h40;
`endif
        redirect_valid = 1'b0; exp_q.delete();
        run_deliver("ma", 1);
    endtask

    task automatic test_halt();
        find_req("ht");
        halt = 1'b1;
        tick();
        halt = 1'b0;
        run_deliver("ht", 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL ht_req got %b want 0", o_req); end
        end
        checks++; if (o_halted !== 1'b1) begin errors++; $display("FAIL ht_halted got %b want 1", o_halted); end
    endtask

    task automatic test_reset_mid_hold();
        logic found = 1'b0;
        rst_n = 1'b0;
        tick();
        checks++; if (o_halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b want 0", o_halted); end
        rst_n = 1'b1; exp_q.delete(); exp_addr = 8'h00; if_ready = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (o_req) begin
                checks++; if (o_addr !== exp_addr) begin errors++; $display("FAIL rst_addr got %h want %h", o_addr, exp_addr); end
                exp_addr += 8'd4;
            end
            if (o_valid) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL rst_hold_timeout got no if_valid want if_valid"); end
        rst_n = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b want 0", if_valid); end
        checks++; if (if_pc !== 8'h00)   begin errors++; $display("FAIL rst_async_pc got %h want 00", if_pc); end
        tick();
        rst_n = 1'b1; if_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap();
        test_misalign();
        test_halt();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
